// File: rtl/lights_pkg.sv
// rtl/lights_pkg.sv - shared WS2811 timing formulas and serializer state encoding
package lights_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SHIFT = 2'd2,
    ST_LATCH = 2'd3
  } ws_state_t;

  // Full bit period at the 800 kHz line rate
  function automatic int t_bit_cycles(input int clk_hz);
    return clk_hz / 800000;
  endfunction

  // High time of a 0 bit (0.4 us)
  function automatic int t0h_cycles(input int clk_hz);
    return clk_hz / 2500000;
  endfunction

  // High time of a 1 bit (0.8 us)
  function automatic int t1h_cycles(input int clk_hz);
    return clk_hz / 1250000;
  endfunction

  // Low time that makes the string latch the frame (50 us)
  function automatic int t_latch_cycles(input int clk_hz);
    return clk_hz / 20000;
  endfunction

endpackage

// File: rtl/ws2811_bit_timer.sv
// rtl/ws2811_bit_timer.sv - per-bit period counter and DO high/low phase decode
module ws2811_bit_timer
  import lights_pkg::*;
#(
  parameter int SYSTEM_CLOCK = 50000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic bit_value,
  output logic level,
  output logic bit_first,
  output logic bit_last
);

  localparam int T_BIT = t_bit_cycles(SYSTEM_CLOCK);
  localparam int T0H   = t0h_cycles(SYSTEM_CLOCK);
  localparam int T1H   = t1h_cycles(SYSTEM_CLOCK);
  localparam int CW    = $clog2(T_BIT + 1);

  logic [CW-1:0] count;
  logic [CW-1:0] high_len;

  // Counts cycles within the current bit; parks at zero when not serialising
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (!run || bit_last) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  // Decode bit boundaries and whether the line is in the high phase
  always_comb begin
    high_len  = bit_value ? CW'(T1H) : CW'(T0H);
    bit_first = run && (count == '0);
    bit_last  = run && (count == CW'(T_BIT - 1));
    level     = run && (count < high_len);
  end

endmodule

// File: rtl/ws2811_serializer.sv
// rtl/ws2811_serializer.sv - WS2811 frame serializer with one-pixel prefetch
module ws2811_serializer
  import lights_pkg::*;
#(
  parameter int NUM_LEDS     = 150,
  parameter int SYSTEM_CLOCK = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       sending,
  output logic [7:0] address,
  output logic       data_request,
  input  logic [7:0] red_in,
  input  logic [7:0] green_in,
  input  logic [7:0] blue_in,
  output logic       DO
);

  localparam int          T_LATCH  = t_latch_cycles(SYSTEM_CLOCK);
  localparam int          LW       = $clog2(T_LATCH + 1);
  localparam logic [7:0]  LAST_PIX = 8'(NUM_LEDS - 1);
  localparam logic [4:0]  LAST_BIT = 5'd23;

  ws_state_t     state;
  ws_state_t     next_state;
  logic [23:0]   shift_reg;
  logic [23:0]   shadow_reg;
  logic [4:0]    bit_idx;
  logic [7:0]    pix_idx;
  logic [LW-1:0] latch_cnt;
  logic          req_pend;
  logic          loaded;
  logic          run;
  logic          level;
  logic          bit_first;
  logic          bit_last;
  logic          frame_end;
  logic          latch_done;

  assign run        = (state == ST_SHIFT);
  assign frame_end  = bit_last && (bit_idx == LAST_BIT) && (pix_idx == LAST_PIX);
  assign latch_done = (latch_cnt == LW'(T_LATCH - 1));

  ws2811_bit_timer #(
    .SYSTEM_CLOCK(SYSTEM_CLOCK)
  ) u_bit_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .bit_value(shift_reg[23]),
    .level    (level),
    .bit_first(bit_first),
    .bit_last (bit_last)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; start only matters in IDLE
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (start)      next_state = ST_FETCH;
      ST_FETCH: if (loaded)     next_state = ST_SHIFT;
      ST_SHIFT: if (frame_end)  next_state = ST_LATCH;
      ST_LATCH: if (latch_done) next_state = ST_IDLE;
      default:                  next_state = ST_IDLE;
    endcase
  end

  // Outputs decoded from state and the bit timer, so reset clears them at once
  always_comb begin
    sending = (state != ST_IDLE);
    DO      = (state == ST_SHIFT) && level;
  end

  // Upstream handshake, pixel/bit counters and shift/shadow registers.
  // req_pend marks the cycle whose closing edge is the 2nd after the request edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      address      <= '0;
      data_request <= 1'b0;
      req_pend     <= 1'b0;
      loaded       <= 1'b0;
      pix_idx      <= '0;
      bit_idx      <= '0;
      shift_reg    <= '0;
      shadow_reg   <= '0;
    end else begin
      data_request <= 1'b0;
      req_pend     <= data_request;
      case (state)
        ST_IDLE: begin
          loaded <= 1'b0;
          if (start) begin
            address      <= '0;
            data_request <= 1'b1;
            pix_idx      <= '0;
            bit_idx      <= '0;
          end
        end
        ST_FETCH: begin
          if (req_pend) begin
            shift_reg <= {green_in, red_in, blue_in};
            loaded    <= 1'b1;
          end
        end
        ST_SHIFT: begin
          loaded <= 1'b0;
          if (bit_first && (bit_idx == '0) && (pix_idx != LAST_PIX)) begin
            address      <= pix_idx + 8'd1;
            data_request <= 1'b1;
          end
          if (req_pend) begin
            shadow_reg <= {green_in, red_in, blue_in};
          end
          if (bit_last) begin
            if (bit_idx == LAST_BIT) begin
              bit_idx <= '0;
              if (pix_idx != LAST_PIX) begin
                pix_idx   <= pix_idx + 8'd1;
                shift_reg <= shadow_reg;
              end else begin
                shift_reg <= '0;
              end
            end else begin
              bit_idx   <= bit_idx + 5'd1;
              shift_reg <= {shift_reg[22:0], 1'b0};
            end
          end
        end
        default: begin
          loaded <= 1'b0;
        end
      endcase
    end
  end

  // Latch gap counter, cleared whenever the serializer is not latching
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      latch_cnt <= '0;
    end else if ((state == ST_LATCH) && !latch_done) begin
      latch_cnt <= latch_cnt + 1'b1;
    end else begin
      latch_cnt <= '0;
    end
  end

endmodule
